pe_systolic_mac: RTL and testbench

PE_SYSTOLIC_MAC -- requirements
Module: pe_systolic_mac

---
 rtl/pe_pkg.sv | 52 +++++
 rtl/pe_mult_stage.sv | 48 ++++
 rtl/pe_systolic_mac.sv | 148 ++++++++++++++
 tb/tb_pe_systolic_mac.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared defaults and the saturating-accumulate helper for the systolic MAC processing element.
package pe_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ACC_W   = 20;
    localparam int DEF_K_DEPTH = 9;

    // Widest accumulator the helper handles; callers extend operands to this width.
    localparam int SUM_W  = 64;
    localparam int SUM_W2 = SUM_W + 2;

    typedef struct packed {
        logic             sat;
        logic [SUM_W-1:0] sum;
    } sat_res_t;

    // Adds two pre-extended operands and clamps to the w-bit range of the chosen signedness.
    function automatic sat_res_t sat_add(
        input logic [SUM_W-1:0] x,
        input logic [SUM_W-1:0] y,
        input int unsigned      w,
        input logic             is_signed,
        input logic             sat_en
    );
        logic signed [SUM_W2-1:0] s;
        logic signed [SUM_W2-1:0] hi;
        logic signed [SUM_W2-1:0] lo;
        sat_res_t                 r;
        if (is_signed) begin
            s  = $signed({{2{x[SUM_W-1]}}, x}) + $signed({{2{y[SUM_W-1]}}, y});
            hi = (SUM_W2'(1) <<< (w - 1)) - SUM_W2'(1);
            lo = -(SUM_W2'(1) <<< (w - 1));
        end else begin
            s  = $signed({2'b00, x}) + $signed({2'b00, y});
            hi = (SUM_W2'(1) <<< w) - SUM_W2'(1);
            lo = '0;
        end
        r.sat = 1'b0;
        r.sum = s[SUM_W-1:0];
        if (sat_en) begin
            if (s > hi) begin
                r.sat = 1'b1;
                r.sum = hi[SUM_W-1:0];
            end else if (s < lo) begin
                r.sat = 1'b1;
                r.sum = lo[SUM_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_mult_stage.sv
// Stage 1 of the PE: registered DATA_W x DATA_W multiply carrying a product-valid bit.
module pe_mult_stage import pe_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SIGNED = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    input  logic                i_valid,
    output logic [2*DATA_W-1:0] o_prod,
    output logic                o_valid
);

    localparam int PW = 2 * DATA_W;

    logic [PW-1:0] w_prod_p0;
    logic [PW-1:0] r_prod_p1;
    logic          r_vld_p1;

    always_comb begin
        if (SIGNED != 0) begin
            w_prod_p0 = PW'($signed(i_a)) * PW'($signed(i_b));
        end else begin
            w_prod_p0 = PW'(i_a) * PW'(i_b);
        end
    end

    // ---- stage 0 -> stage 1 ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= i_valid & ~i_clr;
        end
    end

    always_ff @(posedge clk) begin
        if (i_valid) begin
            r_prod_p1 <= w_prod_p0;
        end
    end

    assign o_prod  = r_prod_p1;
    assign o_valid = r_vld_p1;

endmodule

// File: rtl/pe_systolic_mac.sv
// Systolic MAC processing element: forwards operands to its neighbour and accumulates
// K_DEPTH-beat dot products into a held result with an overrun flag.
module pe_systolic_mac import pe_pkg::*; #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int K_DEPTH = DEF_K_DEPTH,
    parameter int SIGNED  = 0,
    parameter int SAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out,
    output logic              out_sat,
    input  logic              out_ready,
    output logic              res_valid,
    output logic              ovf
);

    localparam int               PW    = 2 * DATA_W;
    localparam int               CNT_W = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(K_DEPTH - 1);

    logic [DATA_W-1:0] r_out_a;
    logic [DATA_W-1:0] r_out_b;
    logic              r_out_valid;

    logic [PW-1:0]     w_prod_p1;
    logic              w_vld_p1;

    logic [ACC_W-1:0]  w_prod_ext_p1;
    logic [SUM_W-1:0]  w_acc_wide;
    logic [SUM_W-1:0]  w_prod_wide;
    sat_res_t          w_add_p1;
    logic              w_first_p1;
    logic              w_last_p1;
    logic [ACC_W-1:0]  w_sum_p1;
    logic              w_sat_p1;
    logic              w_unused_sum;

    logic [CNT_W-1:0]  r_cnt_p2;
    logic [ACC_W-1:0]  r_acc_p2;
    logic              r_sat_p2;
    logic [ACC_W-1:0]  r_out;
    logic              r_out_sat;
    logic              r_res_valid;
    logic              r_ovf;

    // ---- systolic forward ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_a     <= a;
            r_out_b     <= b;
            r_out_valid <= in_valid;
        end
    end

    // ---- stage 0 -> stage 1 ----
    pe_mult_stage #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (clr),
        .i_a     (a),
        .i_b     (b),
        .i_valid (in_valid),
        .o_prod  (w_prod_p1),
        .o_valid (w_vld_p1)
    );

    always_comb begin
        if (SIGNED != 0) begin
            w_prod_ext_p1 = ACC_W'($signed(w_prod_p1));
            w_acc_wide    = SUM_W'($signed(r_acc_p2));
            w_prod_wide   = SUM_W'($signed(w_prod_p1));
        end else begin
            w_prod_ext_p1 = ACC_W'(w_prod_p1);
            w_acc_wide    = SUM_W'(r_acc_p2);
            w_prod_wide   = SUM_W'(w_prod_p1);
        end
        w_add_p1   = sat_add(w_acc_wide, w_prod_wide, ACC_W, SIGNED != 0, SAT != 0);
        w_first_p1 = (r_cnt_p2 == '0);
        w_last_p1  = (r_cnt_p2 == LAST);
        // The first beat loads rather than adds, so a stale accumulator never leaks in.
        w_sum_p1   = w_first_p1 ? w_prod_ext_p1 : w_add_p1.sum[ACC_W-1:0];
        w_sat_p1   = w_first_p1 ? 1'b0 : (r_sat_p2 | w_add_p1.sat);
    end

    assign w_unused_sum = ^w_add_p1.sum;

    // ---- stage 1 -> stage 2 / result channel ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_p2    <= '0;
            r_acc_p2    <= '0;
            r_sat_p2    <= 1'b0;
            r_out       <= '0;
            r_out_sat   <= 1'b0;
            r_res_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (r_res_valid && out_ready) begin
                r_res_valid <= 1'b0;
            end
            if (clr) begin
                r_cnt_p2 <= '0;
                r_acc_p2 <= '0;
                r_sat_p2 <= 1'b0;
            end else if (w_vld_p1) begin
                r_acc_p2 <= w_sum_p1;
                if (w_last_p1) begin
                    r_cnt_p2    <= '0;
                    r_sat_p2    <= 1'b0;
                    r_out       <= w_sum_p1;
                    r_out_sat   <= w_sat_p1;
                    r_res_valid <= 1'b1;
                    if (r_res_valid && !out_ready) begin
                        r_ovf <= 1'b1;
                    end
                end else begin
                    r_cnt_p2 <= r_cnt_p2 + CNT_W'(1);
                    r_sat_p2 <= w_sat_p1;
                end
            end
        end
    end

    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign out_sat   = r_out_sat;
    assign res_valid = r_res_valid;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pe_systolic_mac.sv
// Directed bench for pe_systolic_mac: five parameterisations share one operand bus,
// expected results are queued as beats are driven and popped when a result appears.
module tb_pe_systolic_mac;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       clr       = 1'b0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] a         = 8'h00;
    logic [7:0] b         = 8'h00;

    always #5 clk = ~clk;

    logic [7:0]  oa   [5];
    logic [7:0]  ob   [5];
    logic        ovld [5];
    logic        osat [5];
    logic        rv   [5];
    logic        ovf  [5];
    logic [19:0] ov0, ov3, ov4;
    logic [15:0] ov1, ov2;

    // Per-instance configuration used by the reference model: signedness, width, saturation.
    localparam int SG [5] = '{0, 1, 1, 1, 0};
    localparam int AW [5] = '{20, 16, 16, 20, 20};
    localparam int ST [5] = '{1, 1, 0, 1, 1};

    pe_systolic_mac #(.DATA_W(8), .ACC_W(20), .K_DEPTH(4), .SIGNED(0), .SAT(1)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .a(a), .b(b), .in_valid(in_valid),
        .out_a(oa[0]), .out_b(ob[0]), .out_valid(ovld[0]), .out(ov0), .out_sat(osat[0]),
        .out_ready(out_ready), .res_valid(rv[0]), .ovf(ovf[0]));

    pe_systolic_mac #(.DATA_W(8), .ACC_W(16), .K_DEPTH(4), .SIGNED(1), .SAT(1)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .a(a), .b(b), .in_valid(in_valid),
        .out_a(oa[1]), .out_b(ob[1]), .out_valid(ovld[1]), .out(ov1), .out_sat(osat[1]),
        .out_ready(out_ready), .res_valid(rv[1]), .ovf(ovf[1]));

    pe_systolic_mac #(.DATA_W(8), .ACC_W(16), .K_DEPTH(4), .SIGNED(1), .SAT(0)) u2 (
        .clk(clk), .rst(rst), .clr(clr), .a(a), .b(b), .in_valid(in_valid),
        .out_a(oa[2]), .out_b(ob[2]), .out_valid(ovld[2]), .out(ov2), .out_sat(osat[2]),
        .out_ready(out_ready), .res_valid(rv[2]), .ovf(ovf[2]));

    pe_systolic_mac #(.DATA_W(8), .ACC_W(20), .K_DEPTH(2), .SIGNED(1), .SAT(1)) u3 (
        .clk(clk), .rst(rst), .clr(clr), .a(a), .b(b), .in_valid(in_valid),
        .out_a(oa[3]), .out_b(ob[3]), .out_valid(ovld[3]), .out(ov3), .out_sat(osat[3]),
        .out_ready(out_ready), .res_valid(rv[3]), .ovf(ovf[3]));

    pe_systolic_mac #(.DATA_W(8), .ACC_W(20), .K_DEPTH(1), .SIGNED(0), .SAT(1)) u4 (
        .clk(clk), .rst(rst), .clr(clr), .a(a), .b(b), .in_valid(in_valid),
        .out_a(oa[4]), .out_b(ob[4]), .out_valid(ovld[4]), .out(ov4), .out_sat(osat[4]),
        .out_ready(out_ready), .res_valid(rv[4]), .ovf(ovf[4]));

    typedef struct {
        int          sel;
        logic [19:0] val;
        logic        sat;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [19:0] get_out(input int sel);
        case (sel)
            0:       return ov0;
            1:       return {4'h0, ov1};
            2:       return {4'h0, ov2};
            3:       return ov3;
            default: return ov4;
        endcase
    endfunction

    // Reference: k identical beats of av*bv, clamped after every beat when saturating.
    function automatic exp_t model(input int sel, input logic [7:0] av, input logic [7:0] bv,
                                   input int k);
        longint one, p, s, hi, lo;
        exp_t   e;
        one = 1;
        if (SG[sel] != 0) begin
            p  = longint'($signed(av)) * longint'($signed(bv));
            hi = (one <<< (AW[sel] - 1)) - 1;
            lo = -(one <<< (AW[sel] - 1));
        end else begin
            p  = longint'(av) * longint'(bv);
            hi = (one <<< AW[sel]) - 1;
            lo = 0;
        end
        s     = 0;
        e.sat = 1'b0;
        for (int i = 0; i < k; i++) begin
            s = s + p;
            if (ST[sel] != 0) begin
                if (s > hi) begin
                    s     = hi;
                    e.sat = 1'b1;
                end else if (s < lo) begin
                    s     = lo;
                    e.sat = 1'b1;
                end
            end
        end
        e.sel = sel;
        e.val = 20'(s & ((one <<< AW[sel]) - 1));
        return e;
    endfunction

    task automatic push(input exp_t e);
        sbq.push_back(e);
    endtask

    task automatic push_const(input int sel, input logic [19:0] val, input logic sat);
        exp_t e;
        e.sel = sel;
        e.val = val;
        e.sat = sat;
        sbq.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] av, input logic [7:0] bv);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        step();
    endtask

    task automatic idle();
        a        = 8'h00;
        b        = 8'h00;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_result(input string tag, input int sel);
        exp_t e;
        int   n = 0;
        while (!rv[sel] && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(rv[sel]), 32'd1);
        if (sbq.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_out"}, 32'(get_out(sel)), 32'(e.val));
            chk({tag, "_sat"}, 32'(osat[sel]), 32'(e.sat));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with no clock edge yet.
        #1 rst = 1'b0;
        #1;
        chk("rst_out_a", 32'(oa[0]), 32'd0);
        chk("rst_out_valid", 32'(ovld[0]), 32'd0);
        chk("rst_out", 32'(get_out(0)), 32'd0);
        chk("rst_res_valid", 32'(rv[0]), 32'd0);
        chk("rst_ovf", 32'(ovf[0]), 32'd0);
        step();
        step();
        rst = 1'b1;

        // Unsigned 3x5 over four beats, exact latency and handshake drop.
        for (int i = 0; i < 4; i++) begin
            if (i == 3) push(model(0, 8'd3, 8'd5, 4));
            beat(8'd3, 8'd5);
        end
        chk("lat_early", 32'(rv[0]), 32'd0);
        idle();
        step();
        chk("lat_exact", 32'(rv[0]), 32'd1);
        wait_result("dot_3x5", 0);
        step();
        chk("hs_drop", 32'(rv[0]), 32'd0);

        // Signed 127x127 saturating vs wrapping in a 16-bit accumulator.
        do_reset();
        for (int i = 0; i < 4; i++) beat(8'd127, 8'd127);
        push(model(1, 8'd127, 8'd127, 4));
        push(model(2, 8'd127, 8'd127, 4));
        idle();
        step();
        wait_result("sat16", 1);
        wait_result("wrap16", 2);

        // Signed -128x2 over two beats plus the systolic forward path.
        do_reset();
        beat(8'h80, 8'd2);
        chk("fwd_a", 32'(oa[3]), 32'h80);
        chk("fwd_b", 32'(ob[3]), 32'd2);
        chk("fwd_v", 32'(ovld[3]), 32'd1);
        push(model(3, 8'h80, 8'd2, 2));
        beat(8'h80, 8'd2);
        idle();
        step();
        chk("fwd_idle_v", 32'(ovld[3]), 32'd0);
        chk("fwd_idle_a", 32'(oa[3]), 32'd0);
        wait_result("neg512", 3);

        // K_DEPTH=1: one result per beat, back to back.
        do_reset();
        push(model(4, 8'd2, 8'd3, 1));
        beat(8'd2, 8'd3);
        chk("k1_lat", 32'(rv[4]), 32'd0);
        push(model(4, 8'd4, 8'd5, 1));
        beat(8'd4, 8'd5);
        wait_result("k1_b0", 4);
        push(model(4, 8'd255, 8'd255, 1));
        beat(8'd255, 8'd255);
        wait_result("k1_b1", 4);
        idle();
        step();
        wait_result("k1_b2", 4);

        // Overrun: two results complete while the consumer stalls.
        do_reset();
        out_ready = 1'b0;
        beat(8'd1, 8'd1);
        beat(8'd2, 8'd2);
        beat(8'd1, 8'd1);
        beat(8'd2, 8'd2);
        push_const(0, 20'd10, 1'b0);
        idle();
        step();
        wait_result("ovr_first", 0);
        chk("ovr_first_ovf", 32'(ovf[0]), 32'd0);
        beat(8'd1, 8'd1);
        beat(8'd3, 8'd3);
        beat(8'd1, 8'd1);
        beat(8'd3, 8'd3);
        push_const(0, 20'd20, 1'b0);
        idle();
        step();
        wait_result("ovr_second", 0);
        chk("ovr_second_ovf", 32'(ovf[0]), 32'd1);
        out_ready = 1'b1;
        step();
        chk("ovr_drain_rv", 32'(rv[0]), 32'd0);
        chk("ovr_drain_ovf", 32'(ovf[0]), 32'd1);

        // Abort after two beats; the beat during clr is forwarded only.
        beat(8'd3, 8'd5);
        beat(8'd3, 8'd5);
        clr = 1'b1;
        beat(8'd7, 8'd7);
        clr = 1'b0;
        chk("clr_fwd_a", 32'(oa[0]), 32'd7);
        for (int i = 0; i < 4; i++) beat(8'd1, 8'd1);
        push(model(0, 8'd1, 8'd1, 4));
        idle();
        step();
        wait_result("clr_fresh", 0);
        chk("clr_keeps_ovf", 32'(ovf[0]), 32'd1);

        // Reset mid-product: outputs clear at once, next result starts at beat 0.
        beat(8'd9, 8'd9);
        beat(8'd9, 8'd9);
        idle();
        rst = 1'b0;
        #1;
        chk("mid_rst_out", 32'(get_out(0)), 32'd0);
        chk("mid_rst_ovf", 32'(ovf[0]), 32'd0);
        chk("mid_rst_out_valid", 32'(ovld[0]), 32'd0);
        chk("mid_rst_out_a", 32'(oa[0]), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) beat(8'd2, 8'd2);
        push(model(0, 8'd2, 8'd2, 4));
        idle();
        step();
        wait_result("post_rst", 0);
        chk("queue_drained", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
